// File: rtl/div_tick_select.sv
// div_tick_select
//   Turns the 2/4/8 divider outputs into a one-cycle clock enable (tick) at a
//   selectable rate. Rate changes are handshaked and take effect on the /8
//   count wrap, so the new rate starts phase-aligned. If that wrap never
//   arrives, the switch is forced after TMO_CYC cycles and align_err is set.
//
//   Optional feature macro: DIV_TICK_CNT_EN
//     defined   -> tick_cnt counts ticks since the last rate switch
//     undefined -> no counter, tick_cnt tied to 0
//
//   Ports
//     clk, rst                      system clock, async active-high reset
//     clk_div2/4/8                  divider levels, registered on clk upstream
//     sel_req, sel[1:0]             rate change request and requested rate
//     sel_ack                       one-cycle pulse, requested rate in effect
//     busy                          switch pending, requests ignored
//     active_sel[1:0]               rate currently driving tick
//     tick                          one-cycle enable at the active rate
//     tick_cnt[CNT_W-1:0]           ticks since last switch (see macro)
//     align_err                     last switch was forced by timeout
//
//   state      | meaning
//   IDLE       | accepting requests
//   WAIT_ALIGN | new rate latched, waiting for /8 wrap or timeout
//   ACK        | switch done (or rate unchanged), sel_ack follows
module div_tick_select #(
  parameter int         CNT_W   = 16,
  parameter logic [1:0] RST_SEL = 2'd3,
  parameter int         TMO_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div2,
  input  logic             clk_div4,
  input  logic             clk_div8,
  input  logic             sel_req,
  input  logic [1:0]       sel,
  output logic             sel_ack,
  output logic             busy,
  output logic [1:0]       active_sel,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             align_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ALIGN, ACK} state_t;

  // Timeout is a down-counter: loaded with TMO_CYC-1 on accept, the switch
  // is forced in the WAIT_ALIGN cycle where it reads zero.
  localparam logic [7:0] TMO_LOAD = 8'(TMO_CYC - 1);

  state_t     state, state_nxt;
  logic       prev2, prev4, prev8;
  logic       rise2, rise4, rise8, align_evt;
  logic [7:0] tmo_cnt;
  logic       tmo_done;
  logic [1:0] pend_sel;
  logic       accept_new, do_switch, forced;
  logic       tick_nxt;

  assign rise2     = clk_div2 & ~prev2;
  assign rise4     = clk_div4 & ~prev4;
  assign rise8     = clk_div8 & ~prev8;
  // /8 falling edge is the divider's count wrap: all inputs are low here.
  assign align_evt = prev8 & ~clk_div8;
  assign tmo_done  = (tmo_cnt == 8'd0);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    accept_new = 1'b0;
    do_switch  = 1'b0;
    forced     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_req) begin
          if (sel == active_sel) begin
            state_nxt = ACK;
          end else begin
            accept_new = 1'b1;
            state_nxt  = WAIT_ALIGN;
          end
        end
      end
      WAIT_ALIGN: begin
        // An align event wins over a simultaneous timeout.
        if (align_evt) begin
          do_switch = 1'b1;
          state_nxt = ACK;
        end else if (tmo_done) begin
          do_switch = 1'b1;
          forced    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tick_nxt = 1'b0;
    case (active_sel)
      2'd0:    tick_nxt = 1'b1;
      2'd1:    tick_nxt = rise2;
      2'd2:    tick_nxt = rise4;
      default: tick_nxt = rise8;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev2      <= 1'b0;
      prev4      <= 1'b0;
      prev8      <= 1'b0;
      tick       <= 1'b0;
      sel_ack    <= 1'b0;
      active_sel <= RST_SEL;
      pend_sel   <= RST_SEL;
      align_err  <= 1'b0;
      tmo_cnt    <= TMO_LOAD;
    end else begin
      state   <= state_nxt;
      prev2   <= clk_div2;
      prev4   <= clk_div4;
      prev8   <= clk_div8;
      tick    <= tick_nxt;
      sel_ack <= (state == ACK);
      if (accept_new) begin
        pend_sel  <= sel;
        align_err <= 1'b0;
        tmo_cnt   <= TMO_LOAD;
      end else if (state == WAIT_ALIGN && !tmo_done) begin
        tmo_cnt <= tmo_cnt - 8'd1;
      end
      if (do_switch) begin
        active_sel <= pend_sel;
        align_err  <= forced;
      end
    end
  end

`ifdef DIV_TICK_CNT_EN
  // Clear on the switch edge takes priority over a tick in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (do_switch) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end
`else
  assign tick_cnt = '0;
`endif

endmodule
